// File: rtl/accum_burst_arbiter.sv
// accum_burst_arbiter: round-robin grant of a shared wrapping accumulator to two burst requesters
module accum_burst_arbiter #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_start,
  input  logic [LEN_W-1:0] i_req0_len,
  input  logic [WIDTH-1:0] i_req0_data,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  output logic             o_done0,
  input  logic             i_req1_start,
  input  logic [LEN_W-1:0] i_req1_len,
  input  logic [WIDTH-1:0] i_req1_data,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  output logic             o_done1,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf,
  output logic             o_busy,
  output logic             o_owner
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf, r_owner, r_last;
  logic [LEN_W-1:0] r_len, r_count;
  logic             w_start, w_winner, w_valid, w_accept;
  logic [LEN_W-1:0] w_len_sel, w_count_nx;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH:0]   w_add;
  always_comb begin
    w_start    = i_req0_start | i_req1_start;
    // a tie goes to whoever was not served last
    w_winner   = (i_req0_start & i_req1_start) ? ~r_last : i_req1_start;
    w_len_sel  = w_winner ? i_req1_len : i_req0_len;
    w_data     = r_owner ? i_req1_data : i_req0_data;
    w_valid    = r_owner ? i_req1_valid : i_req0_valid;
    w_accept   = (r_state == ACCUM) & w_valid;
    w_add      = {1'b0, r_sum} + {1'b0, w_data};
    w_count_nx = r_count + 1'b1;
    w_next     = r_state == IDLE  ? (w_start ? (w_len_sel == '0 ? DONE : ACCUM) : IDLE) :
                 r_state == ACCUM ? ((w_accept && w_count_nx == r_len) ? DONE : ACCUM) :
                 IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
      r_len   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_start) begin
        r_owner <= w_winner;
        r_sum   <= '0;
        r_ovf   <= 1'b0;
        r_count <= '0;
        r_len   <= w_len_sel;
      end else if (w_accept) begin
        r_sum   <= w_add[WIDTH-1:0];
        r_ovf   <= r_ovf | w_add[WIDTH];
        r_count <= w_count_nx;
      end else if (r_state == DONE) begin
        r_last  <= r_owner;
      end
    end
  end
  assign o_req0_ready = (r_state == ACCUM) & ~r_owner;
  assign o_req1_ready = (r_state == ACCUM) & r_owner;
  assign o_done0      = (r_state == DONE) & ~r_owner;
  assign o_done1      = (r_state == DONE) & r_owner;
  assign o_sum        = r_sum;
  assign o_ovf        = r_ovf;
  assign o_busy       = r_state != IDLE;
  assign o_owner      = r_owner;
endmodule
